cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer.sv | 154 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer_if
// Purpose  : Bundles the sequencer's instruction/memory handshake inputs and
//            its datapath control strobes. Clock and reset remain plain ports.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if;
  logic [4:0]  opcode;
  logic        mem_ready;
  logic        skip_cond;
  logic        irq;
  logic        mem_req;
  logic        mem_we_en;
  logic        ir_load;
  logic        w_load;
  logic        pc_load;
  logic        pc_inc;
  logic        save_load;
  logic        int_ack;
  logic        mem_err;
  logic [2:0]  state;
  logic [15:0] instr_count;

  // Sequencer side: consumes opcode/handshakes and drives the strobes.
  modport master (
    input  opcode, mem_ready, skip_cond, irq,
    output mem_req, mem_we_en, ir_load, w_load, pc_load, pc_inc,
           save_load, int_ack, mem_err, state, instr_count
  );

  // Datapath/memory side: the mirror image.
  modport slave (
    output opcode, mem_ready, skip_cond, irq,
    input  mem_req, mem_we_en, ir_load, w_load, pc_load, pc_inc,
           save_load, int_ack, mem_err, state, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle CPU control sequencer. Steps each instruction
//            through fetch, decode, optional memory access and writeback,
//            handles skip and wait-for-interrupt, times out stalled memory
//            accesses, and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15  // 1..255 cycles per access
) (
  input  wire logic           clk,
  input  wire logic           reset,
  cpu_sequencer_if.master     bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC_MEM  = 3'd2,
    S_WRITEBACK = 3'd3,
    S_SKIP      = 3'd4,
    S_WAIT_INT  = 3'd5
  } state_t;

  // Timeout fires on the cycle the stall count would reach MEM_TIMEOUT,
  // i.e. the MEM_TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] instr_count_q, instr_count_d;

  logic [3:0]  op;
  logic        op_mem;
  logic        timeout;
  logic        mem_req_c, mem_we_en_c, ir_load_c, w_load_c, pc_load_c;
  logic        pc_inc_c, save_load_c, int_ack_c, mem_err_c;

  assign op      = bus.opcode[4:1];
  assign op_mem  = (op <= 4'h1) || ((op >= 4'h3) && (op <= 4'h9));
  assign timeout = !bus.mem_ready && (wait_q == TIMEOUT_LAST);

  // Next-state, wait counter, retire counter and combinational strobes.
  always_comb begin
    state_d       = state_q;
    wait_d        = 8'd0;
    instr_count_d = instr_count_q;
    mem_req_c     = 1'b0;
    mem_we_en_c   = 1'b0;
    ir_load_c     = 1'b0;
    w_load_c      = 1'b0;
    pc_load_c     = 1'b0;
    pc_inc_c      = 1'b0;
    save_load_c   = 1'b0;
    int_ack_c     = 1'b0;
    mem_err_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) begin
          mem_err_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (op_mem) begin
          state_d = S_EXEC_MEM;
        end else if (op == 4'hE) begin
          save_load_c = 1'b1;
          state_d     = S_WAIT_INT;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_EXEC_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_en_c = bus.opcode[0] || (op == 4'h1);
        if (bus.mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (timeout) begin
          // Abandon the access and refetch the same instruction.
          mem_err_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        w_load_c = (op == 4'h2) || (op_mem && (op != 4'h1) && !bus.opcode[0]);
        if ((op == 4'hC) || (op == 4'hD) || (op == 4'hF)) begin
          pc_load_c = 1'b1;
        end else begin
          pc_inc_c = 1'b1;
        end
        instr_count_d = instr_count_q + 16'd1;
        if (((op == 4'hA) || (op == 4'hB)) && bus.skip_cond) begin
          state_d = S_SKIP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SKIP: begin
        pc_inc_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_WAIT_INT: begin
        if (bus.irq) begin
          int_ack_c     = 1'b1;
          pc_inc_c      = 1'b1;
          instr_count_d = instr_count_q + 16'd1;
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and counter registers; reset overrides any in-flight transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_q        <= 8'd0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Every strobe is held low while reset is asserted.
  assign bus.mem_req     = mem_req_c   && !reset;
  assign bus.mem_we_en   = mem_we_en_c && !reset;
  assign bus.ir_load     = ir_load_c   && !reset;
  assign bus.w_load      = w_load_c    && !reset;
  assign bus.pc_load     = pc_load_c   && !reset;
  assign bus.pc_inc      = pc_inc_c    && !reset;
  assign bus.save_load   = save_load_c && !reset;
  assign bus.int_ack     = int_ack_c   && !reset;
  assign bus.mem_err     = mem_err_c   && !reset;
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Directed self-checking bench for cpu_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bit order: mem_req, mem_we_en, ir_load, w_load, pc_load,
  //                   pc_inc, save_load, int_ack, mem_err
  function automatic logic [8:0] strobes();
    return {bus.mem_req, bus.mem_we_en, bus.ir_load, bus.w_load, bus.pc_load,
            bus.pc_inc, bus.save_load, bus.int_ack, bus.mem_err};
  endfunction

  localparam logic [8:0] ST_NONE   = 9'b000000000;
  localparam logic [8:0] ST_MREQ   = 9'b100000000;
  localparam logic [8:0] ST_FETCH  = 9'b101000000;
  localparam logic [8:0] ST_STORE  = 9'b110000000;
  localparam logic [8:0] ST_MERR   = 9'b100000001;
  localparam logic [8:0] ST_WB_W   = 9'b000101000;
  localparam logic [8:0] ST_PCINC  = 9'b000001000;
  localparam logic [8:0] ST_SAVE   = 9'b000000100;
  localparam logic [8:0] ST_ACK    = 9'b000001010;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.opcode = 5'h11; bus.mem_ready = 1'b1; bus.irq = 1'b1; bus.skip_cond = 1'b1;
    tick(); tick();
    checks++; if (bus.state !== 3'd0) $display("FAIL reset_state got %0d want 0", bus.state); else passes++;
    checks++; if (bus.instr_count !== 16'd0) $display("FAIL reset_count got %h want 0000", bus.instr_count); else passes++;
    checks++; if (strobes() !== ST_NONE) $display("FAIL reset_strobes got %b want %b", strobes(), ST_NONE); else passes++;
    bus.mem_ready = 1'b0; bus.irq = 1'b0; bus.skip_cond = 1'b0;
    reset = 1'b0; #1;
    checks++; if (strobes() !== ST_MREQ) $display("FAIL post_reset_fetch got %b want %b", strobes(), ST_MREQ); else passes++;
  endtask

  task automatic test_timeout();
    // 30 stalled fetch cycles: error on the 15th and 30th, never ir_load.
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      #1;
      checks++;
      if (strobes() !== ((i % 15 == 0) ? ST_MERR : ST_MREQ))
        $display("FAIL timeout_cycle%0d got %b want %b", i, strobes(), (i % 15 == 0) ? ST_MERR : ST_MREQ);
      else passes++;
      tick();
      checks++; if (bus.state !== 3'd0) $display("FAIL timeout_state%0d got %0d want 0", i, bus.state); else passes++;
    end
    // Ready on the timeout cycle: ready wins.
    for (int i = 1; i <= 14; i++) tick();
    bus.mem_ready = 1'b1; bus.opcode = 5'h04; #1;
    checks++; if (strobes() !== ST_FETCH) $display("FAIL ready_vs_timeout got %b want %b", strobes(), ST_FETCH); else passes++;
    tick();
    checks++; if (bus.state !== 3'd1) $display("FAIL ready_vs_timeout_state got %0d want 1", bus.state); else passes++;
    // Return to a clean FETCH with the counter at zero.
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_add();
    bus.opcode = 5'h10; bus.mem_ready = 1'b1; #1;
    checks++; if (strobes() !== ST_FETCH) $display("FAIL add_fetch got %b want %b", strobes(), ST_FETCH); else passes++;
    tick();
    checks++; if (bus.state !== 3'd1 || strobes() !== ST_NONE) $display("FAIL add_decode got %0d/%b want 1/%b", bus.state, strobes(), ST_NONE); else passes++;
    tick();
    checks++; if (bus.state !== 3'd2 || strobes() !== ST_MREQ) $display("FAIL add_exec got %0d/%b want 2/%b", bus.state, strobes(), ST_MREQ); else passes++;
    tick();
    checks++; if (bus.state !== 3'd3 || strobes() !== ST_WB_W) $display("FAIL add_wb got %0d/%b want 3/%b", bus.state, strobes(), ST_WB_W); else passes++;
    checks++; if (bus.instr_count !== 16'd0) $display("FAIL add_count_pre got %h want 0000", bus.instr_count); else passes++;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.instr_count !== 16'd1) $display("FAIL add_retire got %0d/%h want 0/0001", bus.state, bus.instr_count); else passes++;
  endtask

  task automatic test_sms_skip();
    bus.opcode = 5'h14; bus.mem_ready = 1'b1; bus.skip_cond = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd1) $display("FAIL sms_decode got %0d want 1", bus.state); else passes++;
    tick();
    checks++; if (bus.state !== 3'd3 || strobes() !== ST_PCINC) $display("FAIL sms_wb got %0d/%b want 3/%b", bus.state, strobes(), ST_PCINC); else passes++;
    tick();
    checks++; if (bus.state !== 3'd4 || strobes() !== ST_PCINC) $display("FAIL sms_skip got %0d/%b want 4/%b", bus.state, strobes(), ST_PCINC); else passes++;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.instr_count !== 16'd2) $display("FAIL sms_retire got %0d/%h want 0/0002", bus.state, bus.instr_count); else passes++;
    bus.skip_cond = 1'b0;
  endtask

  task automatic test_wfi();
    bus.opcode = 5'h1C; bus.mem_ready = 1'b1; bus.irq = 1'b0;
    tick();
    checks++; if (bus.state !== 3'd1 || strobes() !== ST_SAVE) $display("FAIL wfi_decode got %0d/%b want 1/%b", bus.state, strobes(), ST_SAVE); else passes++;
    tick();
    for (int i = 1; i <= 10; i++) begin
      checks++; if (bus.state !== 3'd5 || strobes() !== ST_NONE) $display("FAIL wfi_wait%0d got %0d/%b want 5/%b", i, bus.state, strobes(), ST_NONE); else passes++;
      tick();
    end
    bus.irq = 1'b1; #1;
    checks++; if (bus.state !== 3'd5 || strobes() !== ST_ACK) $display("FAIL wfi_ack got %0d/%b want 5/%b", bus.state, strobes(), ST_ACK); else passes++;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.instr_count !== 16'd3) $display("FAIL wfi_retire got %0d/%h want 0/0003", bus.state, bus.instr_count); else passes++;
    // irq still high in FETCH: no ack, no state change.
    bus.mem_ready = 1'b0; #1;
    checks++; if (strobes() !== ST_MREQ) $display("FAIL irq_ignored got %b want %b", strobes(), ST_MREQ); else passes++;
    tick();
    checks++; if (bus.state !== 3'd0) $display("FAIL irq_ignored_state got %0d want 0", bus.state); else passes++;
    bus.irq = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    bus.opcode = 5'h11; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.mem_ready = 1'b0; #1;
    checks++; if (bus.state !== 3'd2 || strobes() !== ST_STORE) $display("FAIL store_exec got %0d/%b want 2/%b", bus.state, strobes(), ST_STORE); else passes++;
    reset = 1'b1; #1;
    checks++; if (strobes() !== ST_NONE) $display("FAIL reset_gates got %b want %b", strobes(), ST_NONE); else passes++;
    tick();
    checks++; if (bus.state !== 3'd0 || bus.mem_we_en !== 1'b0 || bus.instr_count !== 16'd0)
      $display("FAIL mid_reset got %0d/%b/%h want 0/0/0000", bus.state, bus.mem_we_en, bus.instr_count); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    // Preload the counter just below wrap while it is idle in FETCH.
    bus.mem_ready = 1'b0;
    force dut.instr_count_q = 16'hFFFF;
    tick();
    release dut.instr_count_q;
    #1;
    checks++; if (bus.instr_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want FFFF", bus.instr_count); else passes++;
    bus.opcode = 5'h04; bus.mem_ready = 1'b1;
    tick(); tick();
    checks++; if (bus.state !== 3'd3 || strobes() !== ST_WB_W) $display("FAIL wrap_wb got %0d/%b want 3/%b", bus.state, strobes(), ST_WB_W); else passes++;
    tick();
    checks++; if (bus.instr_count !== 16'h0000) $display("FAIL wrap_zero got %h want 0000", bus.instr_count); else passes++;
    tick(); tick(); tick();
    checks++; if (bus.instr_count !== 16'h0001) $display("FAIL wrap_next got %h want 0001", bus.instr_count); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b1;
    bus.opcode = 5'h00; bus.mem_ready = 1'b0; bus.skip_cond = 1'b0; bus.irq = 1'b0;
    test_reset();
    test_timeout();
    test_add();
    test_sms_skip();
    test_wfi();
    test_reset_mid_access();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
